// File: rtl/stutter_scheduler.sv
// Stutter sequencer for N code-block copies: lockstep, round-robin, observation-aligned
// and external modes, with per-copy fairness counters and a run/done FSM.

module stutter_lane #(
  parameter int MAX_STUTTER = 4,
  parameter int CW          = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic done,
  input  logic stut,
  output logic at_max,
  output logic hit
);
  localparam logic [CW-1:0] MAXC = CW'(MAX_STUTTER);

  logic [CW-1:0] cnt, cnt_n;

  always_comb begin
    cnt_n = '0;
    if (!done && stut) cnt_n = (cnt == MAXC) ? MAXC : cnt + CW'(1);
  end

  assign at_max = ~done & (cnt == MAXC);
  assign hit    = en & ~done & stut & (cnt_n == MAXC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt_n;
  end
endmodule

module stutter_scheduler #(
  parameter int N           = 2,
  parameter int MAX_STUTTER = 4,
  parameter int CW          = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [N-1:0] ext_stutter,
  input  logic [N-1:0] done_in,
  input  logic [N-1:0] obs_evt,
  output logic [N-1:0] stutter_out,
  output logic         busy,
  output logic         all_done,
  output logic         fair_viol,
  output logic [2:0]   rr_ptr
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t       state, state_n;
  logic [1:0]   mode_q;
  logic [N-1:0] arrived, arrived_d;
  logic [N-1:0] stut_d;
  logic [N-1:0] at_max, hit;
  logic [2:0]   rr_d;
  logic         start_run, decide, rel, found;

  assign start_run = (state != RUN) & start;
  assign decide    = (state == RUN) & ~(&done_in);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (&done_in) state_n = DONE;
      DONE:    if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state == RUN);
    all_done = (state == DONE);
  end

  stutter_lane #(.MAX_STUTTER(MAX_STUTTER), .CW(CW)) u_lane [N-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_run),
    .en     (decide),
    .done   (done_in),
    .stut   (stut_d),
    .at_max (at_max),
    .hit    (hit)
  );

  assign rel = &(arrived | done_in);

  // Per-cycle stutter decision; only committed while RUN with some copy still live.
  always_comb begin
    stut_d    = '1;
    arrived_d = arrived;
    rr_d      = rr_ptr;
    found     = 1'b0;
    case (mode_q)
      2'd0: stut_d = done_in;
      2'd1: begin
        for (int k = 0; k < N; k++)
          for (int i = 0; i < N; i++)
            if (!found && !done_in[i] && (i == (int'(rr_ptr) + k) % N)) begin
              found     = 1'b1;
              stut_d[i] = 1'b0;
              rr_d      = 3'((i + 1) % N);
            end
      end
      2'd2: begin
        // Release takes priority: an event arriving on the release cycle is dropped.
        if (rel) begin
          arrived_d = '0;
          stut_d    = done_in;
        end else begin
          arrived_d = arrived | (obs_evt & ~stutter_out);
          stut_d    = arrived_d | done_in;
        end
      end
      default: stut_d = (ext_stutter | done_in) & ~at_max;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stutter_out <= '1;
      mode_q      <= 2'd0;
      arrived     <= '0;
      rr_ptr      <= 3'd0;
      fair_viol   <= 1'b0;
    end else if (start_run) begin
      stutter_out <= '1;
      mode_q      <= mode;
      arrived     <= '0;
      rr_ptr      <= 3'd0;
      fair_viol   <= 1'b0;
    end else if (decide) begin
      stutter_out <= stut_d;
      arrived     <= arrived_d;
      rr_ptr      <= rr_d;
      if (mode_q != 2'd3 && |hit) fair_viol <= 1'b1;
    end else begin
      stutter_out <= '1;
    end
  end
endmodule

// File: tb/tb_stutter_scheduler.sv
// Self-checking bench for stutter_scheduler: directed scenarios plus random traffic
// compared cycle by cycle against a rule-level reference model.

module tb_stutter_scheduler;
  localparam int N    = 2;
  localparam int MAXS = 4;
  localparam int CW   = 3;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [1:0]   mode;
  logic [N-1:0] ext_stutter, done_in, obs_evt, stutter_out;
  logic         busy, all_done, fair_viol;
  logic [2:0]   rr_ptr;

  int checks = 0;
  int errors = 0;

  // reference model state
  int           st;   // 0 idle, 1 run, 2 done
  int           m, rr;
  bit           fv;
  logic [N-1:0] so, arr;
  int           cnt[N];

  stutter_scheduler #(.N(N), .MAX_STUTTER(MAXS), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ext_stutter(ext_stutter),
    .done_in(done_in), .obs_evt(obs_evt), .stutter_out(stutter_out), .busy(busy),
    .all_done(all_done), .fair_viol(fair_viol), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    st = 0; m = 0; rr = 0; fv = 0; so = '1; arr = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] ns;
    bit rel, got;
    int g;
    if (st == 1) begin
      if (&done_in) begin
        st = 2; so = '1;
      end else begin
        ns = '1;
        case (m)
          0: ns = done_in;
          1: begin
            got = 0;
            for (int k = 0; k < N; k++) begin
              g = (rr + k) % N;
              for (int i = 0; i < N; i++)
                if (!got && i == g && !done_in[i]) begin
                  got = 1; ns[i] = 1'b0; rr = (g + 1) % N;
                end
            end
          end
          2: begin
            rel = 1;
            for (int i = 0; i < N; i++) if (!(arr[i] | done_in[i])) rel = 0;
            if (rel) begin
              arr = '0; ns = done_in;
            end else begin
              for (int i = 0; i < N; i++) if (obs_evt[i] && !so[i]) arr[i] = 1'b1;
              ns = arr | done_in;
            end
          end
          default: begin
            ns = ext_stutter | done_in;
            for (int i = 0; i < N; i++) if (!done_in[i] && cnt[i] == MAXS) ns[i] = 1'b0;
          end
        endcase
        for (int i = 0; i < N; i++) begin
          if (done_in[i]) cnt[i] = 0;
          else if (ns[i]) begin
            cnt[i] = (cnt[i] < MAXS) ? cnt[i] + 1 : MAXS;
            if (m != 3 && cnt[i] == MAXS) fv = 1;
          end else cnt[i] = 0;
        end
        so = ns;
      end
    end else if (start) begin
      st = 1; m = int'(mode); rr = 0; fv = 0; arr = '0; so = '1;
      for (int i = 0; i < N; i++) cnt[i] = 0;
    end else begin
      so = '1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("stutter_out", 32'(stutter_out), 32'(so));
    chk("busy", 32'(busy), 32'(st == 1));
    chk("all_done", 32'(all_done), 32'(st == 2));
    chk("fair_viol", 32'(fair_viol), 32'(fv));
    chk("rr_ptr", 32'(rr_ptr), 32'(rr));
  endtask

  // Asserts reset between edges and checks the outputs before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_stutter", 32'(stutter_out), 32'(2'b11));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_all_done", 32'(all_done), 32'd0);
    chk("rst_fair_viol", 32'(fair_viol), 32'd0);
    chk("rst_rr_ptr", 32'(rr_ptr), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int z0, z1;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0;
    ext_stutter = '0; done_in = '0; obs_evt = '0;
    model_reset();
    #12;
    chk("reset_stutter", 32'(stutter_out), 32'(2'b11));
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fair_viol", 32'(fair_viol), 32'd0);
    rst_n = 1'b1;
    cycle(); cycle();

    // round-robin alternation, then copy0 done
    mode = 2'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); chk("rr_first", 32'(stutter_out), 32'(2'b10));
    cycle(); chk("rr_second", 32'(stutter_out), 32'(2'b01));
    cycle(); chk("rr_third", 32'(stutter_out), 32'(2'b10));
    done_in = 2'b01;
    cycle(); chk("rr_done0_a", 32'(stutter_out), 32'(2'b01));
    cycle(); chk("rr_done0_b", 32'(stutter_out), 32'(2'b01));
    cycle(); chk("rr_start_ignored", 32'(busy), 32'd1);

    // completion
    done_in = 2'b11;
    cycle();
    chk("done_all_done", 32'(all_done), 32'd1);
    chk("done_stutter", 32'(stutter_out), 32'(2'b11));
    cycle();

    // external mode fairness override
    done_in = '0; ext_stutter = 2'b11; mode = 2'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    z0 = 0; z1 = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (!stutter_out[0]) z0++;
      if (!stutter_out[1]) z1++;
      if (c == 4) chk("ext_forced", 32'(stutter_out), 32'(2'b00));
    end
    chk("ext_zeros0", 32'(z0), 32'd2);
    chk("ext_zeros1", 32'(z1), 32'd2);
    chk("ext_no_viol", 32'(fair_viol), 32'd0);
    async_reset();
    cycle();

    // obs-align violation: copy1 never arrives
    mode = 2'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    obs_evt = 2'b01;
    cycle();
    obs_evt = 2'b00;
    cycle(); cycle();
    chk("viol_not_yet", 32'(fair_viol), 32'd0);
    cycle();
    chk("viol_set", 32'(fair_viol), 32'd1);
    cycle(); cycle();
    chk("viol_sticky", 32'(fair_viol), 32'd1);
    // copy1 arrives: release on the following edge
    obs_evt = 2'b10;
    cycle();
    obs_evt = 2'b00;
    chk("align_hold", 32'(stutter_out), 32'(2'b11));
    cycle();
    chk("align_release", 32'(stutter_out), 32'(2'b00));
    done_in = 2'b11;
    cycle();
    done_in = 2'b00; mode = 2'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("viol_cleared", 32'(fair_viol), 32'd0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      start       = ($urandom_range(0, 7) == 0);
      mode        = 2'($urandom_range(0, 3));
      ext_stutter = N'($urandom);
      obs_evt     = N'($urandom);
      for (int i = 0; i < N; i++) done_in[i] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 149) == 0) async_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
